rf_wb_queue: RTL
================

// Module: rf_wb_queue
// PURPOSE
//  Writer-side companion of reg_file: buffers writeback results from the ALU and load paths in a small
//  in-order FIFO and drains one entry per cycle onto the register-file write port (RegWrite/wr_add/wr_data).
//  Provides pending-write lookup on two source addresses so decode can stall on in-flight destinations.
// PARAMETERS
//  ADDR_SIZE  5   register address width
//  WORD_SIZE  64  data word width
//  DEPTH      4   FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          synchronous reset, active low
//  alu_valid    in   1          ALU result offered
//  alu_rd       in   ADDR_SIZE  ALU destination register
//  alu_data     in   WORD_SIZE  ALU result
//  alu_ready    out  1          ALU result accepted this cycle when alu_valid & alu_ready
//  mem_valid    in   1          load result offered
//  mem_rd       in   ADDR_SIZE  load destination register
//  mem_data     in   WORD_SIZE  load result
//  mem_ready    out  1          load result accepted this cycle when mem_valid & mem_ready
//  RegWrite     out  1          register-file write enable (registered)
//  wr_add       out  ADDR_SIZE  register-file write address (registered)
//  wr_data      out  WORD_SIZE  register-file write data (registered)
//  chk_rs1      in   ADDR_SIZE  lookup address 1
//  chk_rs2      in   ADDR_SIZE  lookup address 2
//  pend1        out  1          write to chk_rs1 still pending (combinational)
//  pend2        out  1          write to chk_rs2 still pending (combinational)
//  count        out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset (rst=0 at edge): rd/wr pointers=0, count=0, RegWrite=0, wr_add=0, wr_data=0; contents discarded,
//    including mid-drain; alu_ready=mem_ready=0 while rst=0.
//  - free = DEPTH - count, taken from registered count; the same-cycle pop is not credited.
//  - mem_ready = (free>=1); alu_ready = (free>=2) | (free>=1 & !mem_valid). Load path has priority.
//  - Both accepted in one cycle: mem entry enqueued first (older), then alu entry.
//  - rd==0 handshake completes normally but the entry is not stored (no count change, no write).
//  - Drain: count>0 at an edge -> pop head; RegWrite<=1, wr_add<=head.rd, wr_data<=head.data. Otherwise
//    RegWrite<=0; wr_add/wr_data hold their last values.
//  - Latency: accepted at cycle N on an empty queue -> RegWrite=1 with that entry during cycle N+2.
//  - Writes leave strictly in acceptance order; at most one write per cycle; no entry is lost or duplicated.
//  - count_next = count + pushes - pop; pointers wrap modulo DEPTH; never overflows (ready gating).
//  - pendX = (chk_rsX!=0) & (any valid FIFO entry with rd==chk_rsX | (RegWrite & wr_add==chk_rsX)).
//    Registered write is pending because reg_file commits it at the end of that cycle.
//  - pendX is 0 during reset and for chk_rsX==0.
// TESTING
//  1 rst=0 for 2 cycles with both valids high -> readies=0, RegWrite=0, wr_add=0, wr_data=0, count=0.
//  2 alu rd=1 data=464 at cycle N -> RegWrite=1, wr_add=1, wr_data=464 in N+2 only; RegWrite=0 in N+3.
//  3 mem rd=17 data=433 and alu rd=2 data=7 in the same cycle -> writes (17,433) then (2,7) on
//    consecutive cycles.
//  4 both valid every cycle, distinct rd/data -> alu_ready drops at free<2, mem_ready drops at free=0,
//    count<=4; write sequence equals acceptance order.
//  5 alu rd=0 data=99 -> alu_ready=1, count unchanged, no RegWrite; chk_rs1=0 -> pend1=0.
//  6 enqueue rd=5, chk_rs1=5 -> pend1=1 until the cycle after RegWrite(wr_add=5); queue 3 entries then
//    rst=0 -> count=0 and no further RegWrite.

Source files
------------

// File: rtl/rf_wb_queue.sv
// Writeback queue: buffers ALU and load results in order and drains one per cycle
// onto the register-file write port, with pending-write lookup for two source registers.
module rf_wb_queue #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 64,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_SIZE-1:0]     alu_rd,
  input  logic [WORD_SIZE-1:0]     alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_SIZE-1:0]     mem_rd,
  input  logic [WORD_SIZE-1:0]     mem_data,
  output logic                     mem_ready,
  output logic                     RegWrite,
  output logic [ADDR_SIZE-1:0]     wr_add,
  output logic [WORD_SIZE-1:0]     wr_data,
  input  logic [ADDR_SIZE-1:0]     chk_rs1,
  input  logic [ADDR_SIZE-1:0]     chk_rs2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_SIZE-1:0] rd_mem_q   [DEPTH];
  logic [WORD_SIZE-1:0] data_mem_q [DEPTH];

  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        alu_slot;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        free;
  logic                 reg_write_q;
  logic [ADDR_SIZE-1:0] wr_add_q;
  logic [WORD_SIZE-1:0] wr_data_q;

  logic                 mem_push, alu_push, pop;
  logic [DEPTH-1:0]     match1, match2;

  // Free space uses the registered count only; the pop happening this cycle is not credited.
  assign free      = CW'(DEPTH) - count_q;
  assign mem_ready = rst & (free != '0);
  assign alu_ready = rst & ((free >= CW'(2)) | ((free != '0) & !mem_valid));

  // Writes to x0 complete the handshake but are dropped.
  assign mem_push  = mem_valid & mem_ready & (mem_rd != '0);
  assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
  assign pop       = (count_q != '0);

  assign alu_slot  = wr_ptr_q + PW'(mem_push);
  assign wr_ptr_d  = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
  assign rd_ptr_d  = rd_ptr_q + PW'(pop);
  assign count_d   = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (mem_push) begin
      rd_mem_q[wr_ptr_q]   <= mem_rd;
      data_mem_q[wr_ptr_q] <= mem_data;
    end
    if (alu_push) begin
      rd_mem_q[alu_slot]   <= alu_rd;
      data_mem_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      wr_add_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      reg_write_q <= pop;
      if (pop) begin
        wr_add_q  <= rd_mem_q[rd_ptr_q];
        wr_data_q <= data_mem_q[rd_ptr_q];
      end
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lookup
      logic [PW-1:0] offset;
      logic          live;
      assign offset     = PW'(gi) - rd_ptr_q;
      assign live       = ({1'b0, offset} < count_q);
      assign match1[gi] = live & (rd_mem_q[gi] == chk_rs1);
      assign match2[gi] = live & (rd_mem_q[gi] == chk_rs2);
    end
  endgenerate

  // The registered write still counts as pending: the register file commits it at cycle end.
  assign pend1 = rst & (chk_rs1 != '0) & ((|match1) | (reg_write_q & (wr_add_q == chk_rs1)));
  assign pend2 = rst & (chk_rs2 != '0) & ((|match2) | (reg_write_q & (wr_add_q == chk_rs2)));

  assign RegWrite = reg_write_q;
  assign wr_add   = wr_add_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;

endmodule
